// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU with valid/ready handshake and iterative multiply
//
// Purpose: executes the 3-bit ALU_control code from the ALU control decoder on
// two WIDTH-bit operands. Single-cycle ops register their result on the edge
// that accepts them; multiply (101) runs a shift-add loop for WIDTH cycles.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     operands and alu_control valid this cycle
//   in_ready     block can accept an operation this cycle
//   alu_control  operation code
//   a, b         operands (rs, rt/immediate)
//   out_valid    result, zero and overflow are valid
//   out_ready    consumer takes the result this cycle
//   result       registered result
//   zero         result == 0
//   overflow     signed overflow for add/sub, else 0
//   busy         multiply in progress
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_ovf_d;
  logic [WIDTH-1:0] acc_d;
  logic             accept;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign overflow  = overflow_q;
  assign busy      = (state_q == S_MUL);

  // Single-cycle datapath; the mul opcode produces nothing here.
  always_comb begin
    sum_d     = a + b;
    diff_d    = a - b;
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (alu_control)
      OP_ADD: begin
        alu_res_d = sum_d;
        alu_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Negated b has the opposite sign, so overflow needs differing input signs.
        alu_res_d = diff_d;
        alu_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res_d = a & b;
      OP_OR:   alu_res_d = a | b;
      OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  alu_res_d = ~(a | b);
      OP_PASS: alu_res_d = b;
      default: alu_res_d = '0;
    endcase
  end

  // One shift-add step; the final step's add is folded into the written result.
  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            if (alu_control == OP_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              count_q  <= '0;
              state_q  <= S_MUL;
            end else begin
              result_q    <= alu_res_d;
              overflow_q  <= alu_ovf_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            result_q    <= acc_d;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            count_q     <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard testbench for alu_exec
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Expected response: {result, zero, overflow}
  logic [W+1:0] exp_q[$];

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a handshake happens on the next edge whenever both are high here.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(result), 64'hDEAD_0000);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("scoreboard", 64'({result, zero, overflow}), 64'(e));
        end
      end
    end
  end

  // Present an op and hold it until accepted; returns at posedge+1 of the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic eo, input bit push);
    int n;
    in_valid = 1'b1; alu_control = op; a = av; b = bv;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        check("issue_timeout", 64'(n), 64'(0));
        break;
      end
    end
    if (push) exp_q.push_back({er, (er == '0), eo});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Negedges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int n, output int busy_cycles, output int ready_seen);
    n = 0; busy_cycles = 0; ready_seen = 0;
    forever begin
      @(negedge clk);
      n++;
      if (out_valid || n > 100) break;
      if (busy) busy_cycles++;
      if (in_ready) ready_seen++;
    end
  endtask

  initial begin
    int n, bc, rs;
    reset = 1'b1; in_valid = 1'b0; alu_control = 3'b000; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_result", 64'(result), 64'h0);
    check("rst_zero", 64'(zero), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_busy_ovf", 64'({busy, overflow}), 64'h0);
    @(posedge clk); #1;

    // add with signed overflow, single-cycle latency
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1);
    in_valid = 1'b0;
    wait_valid(n, bc, rs);
    check("add_latency", 64'(n), 64'(1));
    idle(2);

    issue(3'b001, 32'd5, 32'd5, 32'h0, 1'b0, 1);
    issue(3'b001, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1);
    issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
    issue(3'b100, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    issue(3'b110, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
    issue(3'b111, 32'hDEAD_BEEF, 32'h1234, 32'h1234, 1'b0, 1);
    idle(3);

    // multiply: busy for W cycles, result W edges after the accept edge
    issue(3'b101, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 1);
    in_valid = 1'b1; alu_control = 3'b000; a = 32'h1; b = 32'h1;  // ignored during MUL
    wait_valid(n, bc, rs);
    in_valid = 1'b0;
    check("mul_latency", 64'(n - 1), 64'(W));
    check("mul_busy_cycles", 64'(bc), 64'(W));
    check("mul_in_ready_low", 64'(rs), 64'(0));
    idle(2);
    issue(3'b101, 32'h8000_0000, 32'h2, 32'h0, 1'b0, 1);
    in_valid = 1'b0;
    wait_valid(n, bc, rs);
    idle(2);

    // back-to-back adds at full throughput
    issue(3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    issue(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1);
    issue(3'b000, 32'd3, 32'd3, 32'd6, 1'b0, 1);
    check("b2b_pending", 64'(exp_q.size()), 64'(1));
    idle(3);

    // backpressure
    out_ready = 1'b0;
    issue(3'b010, 32'h0000_00FF, 32'h0000_F0F0, 32'h0000_00F0, 1'b0, 1);
    in_valid = 1'b1; alu_control = 3'b011; a = 32'h0F; b = 32'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({out_valid, in_ready, result}), {30'h0, 1'b1, 1'b0, 32'h0000_00F0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'h1);
    exp_q.push_back({32'h0000_003F, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", 64'({out_valid, result}), {31'h0, 1'b1, 32'h0000_003F});
    idle(2);

    // reset in the middle of a multiply
    issue(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0, 0);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_mul_busy", 64'(busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy_valid", 64'({busy, out_valid}), 64'h0);
    check("mid_rst_idle", 64'({in_ready, zero}), 64'h3);
    @(posedge clk); #1 reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("post_rst_no_output", 64'(out_valid), 64'h0);

    idle(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU that sits directly downstream of the ALU control decoder and consumes its 3-bit ALU_control code.
- Operates on two WIDTH-bit operands and returns a registered result with zero and overflow flags.
- Uses a valid/ready handshake on both sides.
- Single-cycle operations have one cycle of latency; multiply is an iterative shift-add taking WIDTH+1 cycles.

Parameters:
WIDTH, 32, operand and result width in bits (minimum 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands and alu_control are valid this cycle
in_ready  output  1  block can accept an operation this cycle
alu_control  input  3  operation code from the ALU control decoder
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt or immediate)
out_valid  output  1  result, zero and overflow are valid
out_ready  input  1  consumer takes the result this cycle
result  output  WIDTH  registered result
zero  output  1  result == 0
overflow  output  1  signed overflow (add/sub only)
busy  output  1  multiply in progress

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-multiply):
  - result=0, zero=1, overflow=0, out_valid=0, busy=0
  - state=IDLE, all internal iteration registers cleared
- Opcodes:
  - 000 add: a+b
  - 001 sub: a-b
  - 010 and
  - 011 or
  - 100 slt: signed a<b gives 1, else 0, zero-extended
  - 101 mul: low WIDTH bits of a*b
  - 110 nor
  - 111 pass: result=b
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - overflow is set only for 000/001 on a signed overflow, i.e. operand signs (after negating b for sub) agree and the result sign differs. It is 0 for every other opcode.
  - zero is computed from the registered result value.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- An operation is accepted when in_valid && in_ready.
- Output slot:
  - result, zero and overflow hold stable while out_valid=1 && out_ready=0.
  - out_valid clears on out_ready unless a new single-cycle result loads in the same cycle.
- States:
  - IDLE, accept of a single-cycle opcode: next edge loads result/flags and sets out_valid=1 (latency 1). A result may be consumed and a new op accepted in the same cycle, giving a throughput of 1 op/cycle.
  - IDLE, accept of 101: the output is consumed if out_ready, and out_valid goes to 0. Load mcand=a, mplier=b, acc=0, count=0; go to MUL; busy=1.
  - MUL: each cycle, if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, count++.
  - MUL, after count reaches WIDTH-1: on that edge write result=acc (including the final add), set out_valid=1, busy=0, overflow=0, and return to IDLE. Result is visible WIDTH cycles after the accept edge.
  - in_ready=0 throughout MUL; in_valid is ignored.
- alu_control, a and b are sampled only at accept; changes on them during MUL have no effect.
- in_valid without in_ready: nothing is captured; the upstream holds its inputs.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset released, idle: result=0, zero=1, out_valid=0, in_ready=1. Assert reset mid-MUL: busy and out_valid drop immediately, state=IDLE.
- WIDTH=32, add 0x7FFFFFFF+1: result=0x80000000, overflow=1, zero=0, out_valid one cycle after accept. Sub 5-5: result=0, zero=1, overflow=0.
- slt a=0xFFFFFFFF, b=1: result=1. slt 1 vs 0xFFFFFFFF: result=0. nor 0,0: result=0xFFFFFFFF. pass b=0x1234: result=0x1234.
- mul 0x0000FFFF*0x00010001: result=0xFFFFFFFF. busy=1 for 32 cycles, in_ready=0 throughout, out_valid asserts 32 cycles after accept. mul 0x80000000*2: result=0, zero=1.
- Back-to-back adds with out_ready=1, in_valid=1 every cycle: one result per cycle in order (1+1=2, 2+2=4, 3+3=6).
- Backpressure: out_ready=0 for 3 cycles after an and result 0xF0: result held, in_ready=0. Raise out_ready with a pending or: old result consumed, and the new result appears next cycle.
